// File: rtl/sem_intersectie.sv
// Traffic-light controller for an N_FAZE-phase intersection with per-phase pedestrian
// crossings, a shared tick prescaler and a blinking-yellow service mode.
module sem_intersectie #(
    parameter int N_FAZE                = 2,
    parameter int DIV                   = 10,
    parameter int T_VERDE               = 10,
    parameter int T_GALBEN              = 2,
    parameter int T_PIETONI_VERDE       = 12,
    parameter int T_PIETONI_INTERMITENT = 6,
    parameter int T_ROSU_TOT            = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              service_i,
    input  logic [N_FAZE-1:0] pietoni_btn_i,
    output logic [N_FAZE-1:0] verde_o,
    output logic [N_FAZE-1:0] galben_o,
    output logic [N_FAZE-1:0] rosu_o,
    output logic [N_FAZE-1:0] verde_pietoni_o,
    output logic [N_FAZE-1:0] rosu_pietoni_o,
    output logic [1:0]        faza_o,
    output logic              ciclu_done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_VERDE, S_GALBEN, S_PIETONI_VERDE,
        S_PIETONI_INTERMITENT, S_ROSU_TOT, S_SERVICE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        faza_q, faza_d;
    logic [N_FAZE-1:0] req_q, req_d;
    logic [23:0]       presc_q, presc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              blink_q, blink_d;
    logic              done_q, done_d;
    logic [N_FAZE-1:0] verde_q, galben_q, rosu_q, vp_q, rp_q;
    logic [N_FAZE-1:0] verde_d, galben_d, rosu_d, vp_d, rp_d;
    logic [N_FAZE-1:0] fsel, fsel_d, blocked, clr;
    logic [7:0]        t_cur;
    logic              tick, expired, entry;

    always_comb begin
        fsel   = N_FAZE'(1) << faza_q;
        tick   = (presc_q == 24'(DIV - 1));
        case (state_q)
            S_VERDE:               t_cur = 8'(T_VERDE);
            S_GALBEN:              t_cur = 8'(T_GALBEN);
            S_PIETONI_VERDE:       t_cur = 8'(T_PIETONI_VERDE);
            S_PIETONI_INTERMITENT: t_cur = 8'(T_PIETONI_INTERMITENT);
            S_ROSU_TOT:            t_cur = 8'(T_ROSU_TOT);
            default:               t_cur = 8'd1;
        endcase
        expired = tick && (cnt_q == t_cur - 8'd1);

        state_d = state_q;
        faza_d  = faza_q;
        done_d  = 1'b0;
        // Service request preempts every other transition.
        if (service_i && state_q != S_SERVICE) begin
            state_d = S_SERVICE;
        end else begin
            case (state_q)
                S_IDLE:   if (enable) state_d = S_VERDE;
                S_VERDE:  if (expired) state_d = S_GALBEN;
                S_GALBEN: if (expired) state_d = |(req_q & fsel) ? S_PIETONI_VERDE : S_ROSU_TOT;
                S_PIETONI_VERDE:       if (expired) state_d = S_PIETONI_INTERMITENT;
                S_PIETONI_INTERMITENT: if (expired) state_d = S_ROSU_TOT;
                S_ROSU_TOT: if (expired) begin
                    done_d  = (faza_q == 2'(N_FAZE - 1));
                    faza_d  = done_d ? 2'd0 : faza_q + 2'd1;
                    state_d = enable ? S_VERDE : S_IDLE;
                end
                S_SERVICE: if (!service_i) begin
                    state_d = S_IDLE;
                    faza_d  = 2'd0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        entry   = (state_d != state_q);
        presc_d = (entry || tick) ? '0 : presc_q + 24'd1;
        cnt_d   = entry ? '0 : (tick ? cnt_q + 8'd1 : cnt_q);

        if (entry && (state_d == S_PIETONI_INTERMITENT || state_d == S_SERVICE))
            blink_d = 1'b1;
        else if (tick && (state_q == S_PIETONI_INTERMITENT || state_q == S_SERVICE))
            blink_d = ~blink_q;
        else
            blink_d = blink_q;

        // Clear on pedestrian-green entry overrides a coincident press.
        blocked = (state_q == S_PIETONI_VERDE || state_q == S_PIETONI_INTERMITENT) ? fsel : '0;
        clr     = (entry && state_d == S_PIETONI_VERDE) ? fsel : '0;
        req_d   = (req_q | (pietoni_btn_i & ~blocked)) & ~clr;

        // Lamps are decoded from next state so the registered outputs track state_q.
        fsel_d   = N_FAZE'(1) << faza_d;
        verde_d  = (state_d == S_VERDE) ? fsel_d : '0;
        galben_d = ((state_d == S_GALBEN) ? fsel_d : '0)
                 | ((state_d == S_SERVICE && blink_d) ? '1 : '0);
        rosu_d   = (state_d == S_SERVICE) ? '0 : ~(verde_d | galben_d);
        vp_d     = (state_d == S_PIETONI_VERDE ||
                   (state_d == S_PIETONI_INTERMITENT && blink_d)) ? fsel_d : '0;
        rp_d     = ~((state_d == S_PIETONI_VERDE ||
                      state_d == S_PIETONI_INTERMITENT) ? fsel_d : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            faza_q   <= '0;
            req_q    <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            blink_q  <= 1'b0;
            done_q   <= 1'b0;
            verde_q  <= '0;
            galben_q <= '0;
            rosu_q   <= '1;
            vp_q     <= '0;
            rp_q     <= '1;
        end else begin
            state_q  <= state_d;
            faza_q   <= faza_d;
            req_q    <= req_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            done_q   <= done_d;
            verde_q  <= verde_d;
            galben_q <= galben_d;
            rosu_q   <= rosu_d;
            vp_q     <= vp_d;
            rp_q     <= rp_d;
        end
    end

    assign verde_o         = verde_q;
    assign galben_o        = galben_q;
    assign rosu_o          = rosu_q;
    assign verde_pietoni_o = vp_q;
    assign rosu_pietoni_o  = rp_q;
    assign faza_o          = faza_q;
    assign ciclu_done_o    = done_q;

endmodule

// File: tb/tb_sem_intersectie.sv
// Scoreboard bench: the stimulus pushes hand-derived per-cycle lamp vectors, a monitor
// pops and compares them and also checks the green exclusions on every cycle.
module tb_sem_intersectie;

    logic       clk = 1'b0;
    logic       rst_n, enable, service, en1;
    logic [1:0] btn, btn1;
    logic [1:0] v0, g0, r0, vp0, rp0, f0;
    logic [1:0] v1, g1, r1, vp1, rp1, f1;
    logic       d0, d1;

    int edges = 0;
    int k, cur0, cur1;
    int passed = 0;
    int total  = 0;

    typedef struct { int at; logic [12:0] v; } item_t;
    item_t sb0[$];
    item_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    sem_intersectie #(.N_FAZE(2), .DIV(2)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .service_i(service),
        .pietoni_btn_i(btn), .verde_o(v0), .galben_o(g0), .rosu_o(r0),
        .verde_pietoni_o(vp0), .rosu_pietoni_o(rp0), .faza_o(f0), .ciclu_done_o(d0)
    );

    sem_intersectie #(.N_FAZE(2), .DIV(1), .T_VERDE(1), .T_GALBEN(1),
                      .T_PIETONI_VERDE(1), .T_PIETONI_INTERMITENT(1), .T_ROSU_TOT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .service_i(1'b0),
        .pietoni_btn_i(btn1), .verde_o(v1), .galben_o(g1), .rosu_o(r1),
        .verde_pietoni_o(vp1), .rosu_pietoni_o(rp1), .faza_o(f1), .ciclu_done_o(d1)
    );

    function automatic logic [12:0] mk(input logic [1:0] v, g, r, vp, rp, f, input logic d);
        return {v, g, r, vp, rp, f, d};
    endfunction
    function automatic logic [1:0] oh(input logic [1:0] f);
        return 2'b01 << f;
    endfunction
    function automatic logic [12:0] RED(input logic [1:0] f, input logic d);
        return mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b11, f, d);
    endfunction
    function automatic logic [12:0] VER(input logic [1:0] f, input logic d);
        return mk(oh(f), 2'b00, ~oh(f), 2'b00, 2'b11, f, d);
    endfunction
    function automatic logic [12:0] GAL(input logic [1:0] f);
        return mk(2'b00, oh(f), ~oh(f), 2'b00, 2'b11, f, 1'b0);
    endfunction
    function automatic logic [12:0] PVG(input logic [1:0] f);
        return mk(2'b00, 2'b00, 2'b11, oh(f), ~oh(f), f, 1'b0);
    endfunction
    function automatic logic [12:0] PIN(input logic [1:0] f, input logic b);
        return mk(2'b00, 2'b00, 2'b11, b ? oh(f) : 2'b00, ~oh(f), f, 1'b0);
    endfunction
    function automatic logic [12:0] SRV(input logic [1:0] f, input logic b);
        return mk(2'b00, b ? 2'b11 : 2'b00, 2'b00, 2'b00, 2'b11, f, 1'b0);
    endfunction

    task automatic put0(input logic [12:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sb0.push_back('{cur0, v});
            cur0++;
        end
    endtask
    task automatic put1(input logic [12:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sb1.push_back('{cur1, v});
            cur1++;
        end
    endtask
    task automatic at(input int e);
        while (edges < e) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [12:0] a0, a1;
        item_t it;
        a0 = {v0, g0, r0, vp0, rp0, f0, d0};
        a1 = {v1, g1, r1, vp1, rp1, f1, d1};
        while (sb0.size() > 0 && sb0[0].at <= edges) begin
            it = sb0.pop_front();
            total++;
            if (it.at != edges || a0 !== it.v)
                $display("FAIL lamps_u0 edge %0d (due %0d): got %b want %b", edges, it.at, a0, it.v);
            else passed++;
        end
        while (sb1.size() > 0 && sb1[0].at <= edges) begin
            it = sb1.pop_front();
            total++;
            if (it.at != edges || a1 !== it.v)
                $display("FAIL lamps_u1 edge %0d (due %0d): got %b want %b", edges, it.at, a1, it.v);
            else passed++;
        end
        total++;
        if ($countones(v0) > 1 || (v0 & vp0) != 2'b00)
            $display("FAIL excl_u0 edge %0d: verde %b verde_pietoni %b", edges, v0, vp0);
        else passed++;
        total++;
        if ($countones(v1) > 1 || (v1 & vp1) != 2'b00)
            $display("FAIL excl_u1 edge %0d: verde %b verde_pietoni %b", edges, v1, vp1);
        else passed++;
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; service = 1'b0; btn = 2'b00;
        en1 = 1'b0; btn1 = 2'b00;
        @(negedge clk);
        k = edges + 5;
        cur0 = k - 4;
        cur1 = k - 4;

        // u0: DIV=2, default durations
        put0(RED(0, 0), 5);
        put0(VER(0, 0), 20); put0(GAL(0), 4); put0(RED(0, 0), 2);
        put0(VER(1, 0), 20); put0(GAL(1), 4); put0(PVG(1), 24);
        for (int i = 0; i < 3; i++) begin put0(PIN(1, 1), 2); put0(PIN(1, 0), 2); end
        put0(RED(1, 0), 2);
        put0(VER(0, 1), 1); put0(VER(0, 0), 19); put0(GAL(0), 4); put0(RED(0, 0), 2);
        put0(RED(1, 0), 4);
        put0(VER(1, 0), 20); put0(GAL(1), 4); put0(RED(1, 0), 2);
        put0(VER(0, 1), 1); put0(VER(0, 0), 19); put0(GAL(0), 4); put0(PVG(0), 4);
        put0(SRV(0, 1), 2); put0(SRV(0, 0), 2); put0(SRV(0, 1), 2);
        put0(RED(0, 0), 1);
        put0(VER(0, 0), 20); put0(GAL(0), 4); put0(RED(0, 0), 2);
        put0(VER(1, 0), 20); put0(GAL(1), 4); put0(PVG(1), 24);
        for (int i = 0; i < 3; i++) begin put0(PIN(1, 1), 2); put0(PIN(1, 0), 2); end
        put0(RED(1, 0), 2);
        put0(VER(0, 1), 1); put0(VER(0, 0), 19); put0(GAL(0), 2);
        put0(RED(0, 0), 1);
        put0(SRV(0, 1), 2); put0(SRV(0, 0), 1);
        put0(RED(0, 0), 3);

        // u1: DIV=1, every duration 1
        put1(RED(0, 0), 3);
        put1(VER(0, 0), 1); put1(GAL(0), 1); put1(RED(0, 0), 1);
        put1(VER(1, 0), 1); put1(GAL(1), 1); put1(PVG(1), 1); put1(PIN(1, 1), 1);
        put1(RED(1, 0), 1);
        put1(VER(0, 1), 1); put1(GAL(0), 1); put1(RED(0, 0), 1);
        put1(RED(1, 0), 2);

        at(k - 4); rst_n = 1'b1;
        at(k - 2); en1 = 1'b1; btn1 = 2'b10;
        at(k - 1); btn1 = 2'b00;
        at(k);     enable = 1'b1;
        at(k + 5); btn = 2'b10;
        at(k + 6); btn = 2'b00;
        at(k + 7); en1 = 1'b0;
        at(k + 90);  enable = 1'b0;
        at(k + 118); enable = 1'b1;
        at(k + 146); btn = 2'b01;
        at(k + 147); btn = 2'b00;
        at(k + 170); btn = 2'b11;
        at(k + 171); btn = 2'b00;
        at(k + 172); service = 1'b1;
        at(k + 178); service = 1'b0;
        at(k + 289); rst_n = 1'b0; service = 1'b1;
        at(k + 290); rst_n = 1'b1;
        at(k + 293); service = 1'b0; enable = 1'b0;
        at(k + 300);

        if (sb0.size() + sb1.size() != 0) begin
            total += sb0.size() + sb1.size();
            $display("FAIL scoreboard_drain: got %0d unchecked items, want 0", sb0.size() + sb1.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
